// File: rtl/phase_accum_stage_if.sv
// Control/status bundle between the phase-select controller and the
// stage-1 phase accumulator. The controller (master) drives enable, clear
// and FCW update requests. The accumulator (slave) returns the registered
// phase bits, the wrap pulse, the aligned enable and the update-busy flag.
interface phase_accum_stage_if #(
  parameter int ACC_WIDTH = 12
);
  logic                 en;
  logic                 acc_clr;
  logic [ACC_WIDTH-1:0] fcw_in;
  logic                 fcw_load;
  logic                 fcw_busy;
  logic [3:0]           x_s1;
  logic                 carry_s1;
  logic                 en_s1;

  modport master (
    output en,
    output acc_clr,
    output fcw_in,
    output fcw_load,
    input  fcw_busy,
    input  x_s1,
    input  carry_s1,
    input  en_s1
  );

  modport slave (
    input  en,
    input  acc_clr,
    input  fcw_in,
    input  fcw_load,
    output fcw_busy,
    output x_s1,
    output carry_s1,
    output en_s1
  );
endinterface

// File: rtl/phase_accum_stage.sv
// Stage-1 phase accumulator for the clock phase-select path.
// Adds the active frequency control word (FCW) into an ACC_WIDTH-bit
// accumulator on every enabled cycle. The top 4 accumulator bits go to the
// even/odd mux decoder. A new FCW is held in a shadow register and only
// becomes active on a wrap, on a clear, or while accumulation is paused, so
// the selected phase never jumps part-way through a period.
// ACC_WIDTH must lie in 5..32.
module phase_accum_stage #(
  parameter int                   ACC_WIDTH = 12,
  parameter logic [ACC_WIDTH-1:0] FCW_RESET = ACC_WIDTH'(12'h100)
) (
  input  logic               clk,
  input  logic               rst_n,
  phase_accum_stage_if.slave bus
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] fcw_act;
  logic [ACC_WIDTH-1:0] fcw_shadow;
  logic                 busy_r;
  logic                 carry_r;
  logic                 en_d;

  logic [ACC_WIDTH:0]   sum_ext;
  logic                 wrap;
  logic                 commit;

  // Extended-width add gives the wrap carry. A pending word commits when the
  // accumulator wraps, is cleared, or is paused; the last two are safe
  // because no phase step happens on those edges.
  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, fcw_act};
    wrap    = sum_ext[ACC_WIDTH];
    commit  = bus.acc_clr | ~bus.en | wrap;
  end

  // Accumulator, wrap pulse and the one-cycle-delayed enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      carry_r <= 1'b0;
      en_d    <= 1'b0;
    end else begin
      en_d <= bus.en;
      if (bus.acc_clr) begin
        acc     <= '0;
        carry_r <= 1'b0;
      end else if (bus.en) begin
        acc     <= sum_ext[ACC_WIDTH-1:0];
        carry_r <= wrap;
      end else begin
        carry_r <= 1'b0;
      end
    end
  end

  // FCW update FSM: capture into the shadow when idle, then commit to the
  // active word at the next safe edge. Loads while pending are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy_r     <= 1'b0;
      fcw_shadow <= '0;
      fcw_act    <= FCW_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (bus.fcw_load) begin
            fcw_shadow <= bus.fcw_in;
            state      <= PENDING;
            busy_r     <= 1'b1;
          end
        end
        PENDING: begin
          if (commit) begin
            fcw_act <= fcw_shadow;
            state   <= IDLE;
            busy_r  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.x_s1     = acc[ACC_WIDTH-1 -: 4];
  assign bus.carry_s1 = carry_r;
  assign bus.en_s1    = en_d;
  assign bus.fcw_busy = busy_r;

endmodule

// File: tb/tb_phase_accum_stage.sv
// Directed testbench for phase_accum_stage with a 12-bit accumulator and
// FCW_RESET = 0x100. Each task drives one scenario and checks the outputs
// against hand-computed values one time unit after the rising edge.
module tb_phase_accum_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  phase_accum_stage_if #(.ACC_WIDTH(12)) bus ();

  phase_accum_stage #(
    .ACC_WIDTH(12),
    .FCW_RESET(12'h100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.en       = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.fcw_load = 1'b0;
    bus.fcw_in   = 12'h000;
    rst_n        = 1'b1;
    #1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Loads a word while paused, so it commits on the following edge.
  task automatic set_fcw_paused(input logic [11:0] value);
    bus.en       = 1'b0;
    bus.fcw_load = 1'b1;
    bus.fcw_in   = value;
    step();
    bus.fcw_load = 1'b0;
    step();
  endtask

  task automatic test_reset();
    bus.en       = 1'b1;
    bus.acc_clr  = 1'b0;
    bus.fcw_load = 1'b0;
    bus.fcw_in   = 12'h000;
    rst_n        = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    total++; if (bus.x_s1 !== 4'd0) begin bad++; $display("[TB] FAIL reset_x: got %0d want 0", bus.x_s1); end
    total++; if (bus.fcw_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.fcw_busy); end
    total++; if (bus.carry_s1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_carry: got %b want 0", bus.carry_s1); end
    total++; if (bus.en_s1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_en_s1: got %b want 0", bus.en_s1); end
    step();
    total++; if (bus.x_s1 !== 4'd0) begin bad++; $display("[TB] FAIL reset_hold_x: got %0d want 0", bus.x_s1); end
    bus.en = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_accumulate();
    do_reset();
    bus.en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      total++; if (bus.x_s1 !== 4'(k % 16)) begin bad++; $display("[TB] FAIL acc_x k=%0d: got %0d want %0d", k, bus.x_s1, k % 16); end
      total++; if (bus.carry_s1 !== (k == 16)) begin bad++; $display("[TB] FAIL acc_carry k=%0d: got %b want %b", k, bus.carry_s1, (k == 16)); end
      total++; if (bus.en_s1 !== 1'b1) begin bad++; $display("[TB] FAIL acc_en_s1 k=%0d: got %b want 1", k, bus.en_s1); end
    end
  endtask

  task automatic test_midperiod_load();
    do_reset();
    bus.en = 1'b1;
    repeat (3) step();
    bus.fcw_load = 1'b1;
    bus.fcw_in   = 12'h080;
    step();
    bus.fcw_load = 1'b0;
    total++; if (bus.fcw_busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy: got %b want 1", bus.fcw_busy); end
    total++; if (bus.x_s1 !== 4'd4) begin bad++; $display("[TB] FAIL mid_x_load: got %0d want 4", bus.x_s1); end
    for (int k = 5; k <= 15; k++) begin
      step();
      total++; if (bus.x_s1 !== 4'(k)) begin bad++; $display("[TB] FAIL mid_x k=%0d: got %0d want %0d", k, bus.x_s1, k); end
      total++; if (bus.fcw_busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy k=%0d: got %b want 1", k, bus.fcw_busy); end
    end
    step();
    total++; if (bus.x_s1 !== 4'd0) begin bad++; $display("[TB] FAIL mid_wrap_x: got %0d want 0", bus.x_s1); end
    total++; if (bus.carry_s1 !== 1'b1) begin bad++; $display("[TB] FAIL mid_wrap_carry: got %b want 1", bus.carry_s1); end
    total++; if (bus.fcw_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_wrap_busy: got %b want 0", bus.fcw_busy); end
    for (int k = 1; k <= 6; k++) begin
      step();
      total++; if (bus.x_s1 !== 4'(k / 2)) begin bad++; $display("[TB] FAIL mid_new_x k=%0d: got %0d want %0d", k, bus.x_s1, k / 2); end
      total++; if (bus.carry_s1 !== 1'b0) begin bad++; $display("[TB] FAIL mid_new_carry k=%0d: got %b want 0", k, bus.carry_s1); end
    end
  endtask

  task automatic test_load_while_pending();
    do_reset();
    bus.en = 1'b1;
    repeat (2) step();
    bus.fcw_load = 1'b1;
    bus.fcw_in   = 12'h080;
    step();
    bus.fcw_load = 1'b0;
    step();
    bus.fcw_load = 1'b1;
    bus.fcw_in   = 12'h040;
    step();
    bus.fcw_load = 1'b0;
    total++; if (bus.fcw_busy !== 1'b1) begin bad++; $display("[TB] FAIL pend_busy: got %b want 1", bus.fcw_busy); end
    total++; if (bus.x_s1 !== 4'd5) begin bad++; $display("[TB] FAIL pend_x: got %0d want 5", bus.x_s1); end
    for (int k = 6; k <= 15; k++) begin
      step();
      total++; if (bus.x_s1 !== 4'(k)) begin bad++; $display("[TB] FAIL pend_x k=%0d: got %0d want %0d", k, bus.x_s1, k); end
    end
    step();
    total++; if (bus.carry_s1 !== 1'b1) begin bad++; $display("[TB] FAIL pend_wrap_carry: got %b want 1", bus.carry_s1); end
    total++; if (bus.fcw_busy !== 1'b0) begin bad++; $display("[TB] FAIL pend_wrap_busy: got %b want 0", bus.fcw_busy); end
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (bus.x_s1 !== 4'(k / 2)) begin bad++; $display("[TB] FAIL pend_new_x k=%0d: got %0d want %0d", k, bus.x_s1, k / 2); end
    end
  endtask

  task automatic test_clear_with_en();
    do_reset();
    set_fcw_paused(12'h050);
    total++; if (bus.fcw_busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_pause_commit: got %b want 0", bus.fcw_busy); end
    bus.en = 1'b1;
    repeat (32) step();
    total++; if (bus.x_s1 !== 4'hA) begin bad++; $display("[TB] FAIL clr_pre_x: got %0d want 10", bus.x_s1); end
    bus.fcw_load = 1'b1;
    bus.fcw_in   = 12'h200;
    step();
    bus.fcw_load = 1'b0;
    total++; if (bus.x_s1 !== 4'hA) begin bad++; $display("[TB] FAIL clr_a50_x: got %0d want 10", bus.x_s1); end
    total++; if (bus.fcw_busy !== 1'b1) begin bad++; $display("[TB] FAIL clr_a50_busy: got %b want 1", bus.fcw_busy); end
    bus.acc_clr = 1'b1;
    step();
    bus.acc_clr = 1'b0;
    total++; if (bus.x_s1 !== 4'd0) begin bad++; $display("[TB] FAIL clr_x: got %0d want 0", bus.x_s1); end
    total++; if (bus.carry_s1 !== 1'b0) begin bad++; $display("[TB] FAIL clr_carry: got %b want 0", bus.carry_s1); end
    total++; if (bus.fcw_busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_busy: got %b want 0", bus.fcw_busy); end
    step();
    total++; if (bus.x_s1 !== 4'd2) begin bad++; $display("[TB] FAIL clr_after_x: got %0d want 2", bus.x_s1); end
    step();
    total++; if (bus.x_s1 !== 4'd4) begin bad++; $display("[TB] FAIL clr_after2_x: got %0d want 4", bus.x_s1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_fcw_paused(12'h7F0);
    bus.en       = 1'b1;
    bus.fcw_load = 1'b1;
    bus.fcw_in   = 12'h010;
    step();
    bus.fcw_load = 1'b0;
    total++; if (bus.x_s1 !== 4'd7) begin bad++; $display("[TB] FAIL arst_pre_x: got %0d want 7", bus.x_s1); end
    total++; if (bus.fcw_busy !== 1'b1) begin bad++; $display("[TB] FAIL arst_pre_busy: got %b want 1", bus.fcw_busy); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (bus.x_s1 !== 4'd0) begin bad++; $display("[TB] FAIL arst_x: got %0d want 0", bus.x_s1); end
    total++; if (bus.fcw_busy !== 1'b0) begin bad++; $display("[TB] FAIL arst_busy: got %b want 0", bus.fcw_busy); end
    total++; if (bus.en_s1 !== 1'b0) begin bad++; $display("[TB] FAIL arst_en_s1: got %b want 0", bus.en_s1); end
    #2;
    rst_n = 1'b1;
    step();
    total++; if (bus.x_s1 !== 4'd1) begin bad++; $display("[TB] FAIL arst_post_x1: got %0d want 1", bus.x_s1); end
    step();
    total++; if (bus.x_s1 !== 4'd2) begin bad++; $display("[TB] FAIL arst_post_x2: got %0d want 2", bus.x_s1); end
    total++; if (bus.fcw_busy !== 1'b0) begin bad++; $display("[TB] FAIL arst_post_busy: got %b want 0", bus.fcw_busy); end
  endtask

  task automatic test_fcw_max();
    do_reset();
    set_fcw_paused(12'hFFF);
    bus.en = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      step();
      total++; if (bus.x_s1 !== ((k <= 256) ? 4'd15 : 4'd14)) begin bad++; $display("[TB] FAIL max_x k=%0d: got %0d want %0d", k, bus.x_s1, (k <= 256) ? 15 : 14); end
      total++; if (bus.carry_s1 !== (k > 1)) begin bad++; $display("[TB] FAIL max_carry k=%0d: got %b want %b", k, bus.carry_s1, (k > 1)); end
    end
  endtask

  task automatic test_fcw_zero();
    do_reset();
    set_fcw_paused(12'h000);
    bus.en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (bus.x_s1 !== 4'd0) begin bad++; $display("[TB] FAIL zero_x k=%0d: got %0d want 0", k, bus.x_s1); end
      total++; if (bus.carry_s1 !== 1'b0) begin bad++; $display("[TB] FAIL zero_carry k=%0d: got %b want 0", k, bus.carry_s1); end
    end
    bus.fcw_load = 1'b1;
    bus.fcw_in   = 12'h100;
    step();
    bus.fcw_load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (bus.fcw_busy !== 1'b1) begin bad++; $display("[TB] FAIL zero_busy k=%0d: got %b want 1", k, bus.fcw_busy); end
    end
    bus.en = 1'b0;
    step();
    total++; if (bus.fcw_busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_pause_busy: got %b want 0", bus.fcw_busy); end
    total++; if (bus.en_s1 !== 1'b0) begin bad++; $display("[TB] FAIL zero_en_s1: got %b want 0", bus.en_s1); end
    bus.en = 1'b1;
    step();
    total++; if (bus.x_s1 !== 4'd1) begin bad++; $display("[TB] FAIL zero_resume_x1: got %0d want 1", bus.x_s1); end
    total++; if (bus.en_s1 !== 1'b1) begin bad++; $display("[TB] FAIL zero_resume_en_s1: got %b want 1", bus.en_s1); end
    step();
    total++; if (bus.x_s1 !== 4'd2) begin bad++; $display("[TB] FAIL zero_resume_x2: got %0d want 2", bus.x_s1); end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_midperiod_load();
    test_load_while_pending();
    test_clear_with_en();
    test_async_reset();
    test_fcw_max();
    test_fcw_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
